ddr_cmd_decoder: RTL and testbench
==================================

Name: ddr_cmd_decoder

Overview:
- Memory-side receiver for the DDR4 command/address bus: samples the pin-level command driven by the controller, decodes it to a command code with bank/row/column fields, and tracks per-bank state.
- Checks bank-state protocol rules and raises errors on violations.
- Emits read/write data-start strobes after CL/CWL so the memory model can launch or capture the DQ/DQS bursts.
- Sits between the DDR interface pins and the memory behavioural model / scoreboard.

Parameters:
- BG_WIDTH, 2, bank-group address width
- BA_WIDTH, 2, bank address width; NUM_BANKS = 2**(BG_WIDTH+BA_WIDTH)
- ROW_WIDTH, 15, row address width
- COL_WIDTH, 10, column address width
- T_RCD, 11, ACT-to-CAS minimum, in clocks
- T_RP, 11, PRE-to-ACT minimum, in clocks
- T_RFC, 208, REF duration, in clocks
- CL, 11, CAS_R-to-rd_data_start latency, in clocks
- CWL, 9, CAS_W-to-wr_data_start latency, in clocks

Ports:
- clock_n  in  1  command clock; pins sampled on rising edge
- reset_n  in  1  asynchronous active-low reset
- cke  in  1  clock enable; 0 forces NOP decode
- cs_n  in  1  chip select
- act_n  in  1  activate
- ras_n_a16, cas_n_a15, we_n_a14  in  1 each  command / address pins
- addr17, addr13, bc_n_a12, addr11, ap_a10  in  1 each  address pins
- addr9_0  in  10  address
- bg_addr  in  BG_WIDTH  bank group
- ba_addr  in  BA_WIDTH  bank
- cmd_valid  out  1  registered decoded command, non-NOP
- cmd_code  out  4  0 NOP, 1 ACT, 2 PRE, 3 PREA, 4 RD, 5 WR, 6 MRS, 7 REF, 8 ZQCL, 15 ILLEGAL
- cmd_bg, cmd_ba  out  BG_WIDTH / BA_WIDTH  captured bank
- cmd_row  out  ROW_WIDTH  {we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0}; MRS opcode
- cmd_col  out  COL_WIDTH  addr9_0
- rd_data_start  out  1  pulse CL clocks after accepted RD
- wr_data_start  out  1  pulse CWL clocks after accepted WR
- bank_open  out  NUM_BANKS  per-bank ACTIVE flag
- refreshing  out  1  high during tRFC
- protocol_err  out  1  one-cycle error pulse
- err_code  out  3  1 CAS to non-active bank, 2 ACT to non-idle bank, 3 tRCD violation, 4 tRP violation, 5 REF with bank open / during refresh, 6 reserved pin code; holds last value

Behaviour:
- Reset (async, reset_n = 0): all outputs 0, all banks IDLE, all counters and latency pipes cleared, in-flight strobes dropped. Release is synchronous to the clock.

Decode (sampled at posedge clock_n, outputs registered, 1-cycle latency):
- cke = 0 or cs_n = 1: NOP, cmd_valid = 0.
- act_n = 0: ACT.
- act_n = 1, decode {ras, cas, we}:
  - 000 MRS
  - 001 REF
  - 010 PRE; PREA if ap_a10 = 1
  - 100 WR
  - 101 RD
  - 110 ZQCL
  - 111 NOP
  - 011 ILLEGAL, err 6
- X/Z on ras_n_a16, cas_n_a15 or we_n_a14 while cs_n = 1 is ignored (DES).

Per-bank FSM:
- States: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
- Transitions:
  - IDLE -ACT-> ACTIVATING; counter loads T_RCD-1.
  - ACTIVATING -> ACTIVE when counter = 0.
  - ACTIVE or ACTIVATING -PRE-> PRECHARGING; counter loads T_RP-1.
  - PRECHARGING -> IDLE when counter = 0.
- PRE to an IDLE bank is legal and has no effect.
- PREA applies PRE to every non-IDLE bank.
- bank_open[i] = 1 only in ACTIVE.
- Errors (command still reported on cmd_*; bank state unchanged):
  - RD/WR to ACTIVATING bank: err 3.
  - RD/WR to IDLE/PRECHARGING bank: err 1; no strobe generated.
  - ACT to PRECHARGING bank: err 4.
  - ACT to ACTIVATING/ACTIVE bank: err 2.
- Any command other than NOP/DES during refreshing: err 5.

Refresh:
- REF with all banks IDLE: refreshing = 1 for exactly T_RFC cycles.
- REF with any bank not IDLE: err 5, refresh not started.

Latency pipes:
- Separate CL- and CWL-deep shift registers, so multiple RD/WR can be in flight.
- Strobe asserts exactly CL (CWL) clocks after the cmd_valid cycle of the accepted RD (WR).
- Back-to-back commands give back-to-back pulses.
- A bank may be precharged while its strobe is in flight; the strobe is not cancelled.
- Counters saturate at 0; the address fields do not wrap.

Test Plan:
- Reset mid-operation: assert reset_n = 0 with 3 RDs in flight -> all outputs 0 immediately; no rd_data_start after release.
- Legal read: ACT bg=1 ba=2 row=0x1A5C, then after 11 clocks RD col=0x3F8 -> cmd_code 1 then 4; cmd_row 0x1A5C; cmd_col 0x3F8; bank_open[6] = 1; rd_data_start exactly 11 clocks after the RD cmd_valid; no error.
- tRCD violation: ACT then WR 5 clocks later -> protocol_err, err_code 3, no wr_data_start. Repeat WR at 11 clocks -> wr_data_start 9 clocks later.
- Precharge: PREA with banks 0 and 6 open, then ACT bank 0 at +4 -> err 4. ACT at +11 -> accepted, no error.
- Refresh: REF with bank 3 open -> err 5, refreshing = 0. After PRE and T_RP, REF -> refreshing high for 208 cycles. An ACT during refresh -> err 5.
- Decode sweep: drive every {act_n, ras, cas, we} combination with cs_n = 0, plus cs_n = 1 with X on command pins -> codes per table, 011 gives ILLEGAL/err 6, DES gives cmd_valid = 0.

Source files
------------

// File: rtl/ddr_cmd_decoder.sv
// DDR4 command/address receiver: decodes the sampled command pins, tracks per-bank
// state, flags protocol violations and launches CL/CWL-delayed data-start strobes.
//
// Per-bank FSM
//   state         | meaning
//   B_IDLE        | bank precharged, ACT allowed
//   B_ACTIVATING  | ACT accepted, waiting tRCD before CAS
//   B_ACTIVE      | row open, RD/WR allowed
//   B_PRECHARGING | PRE accepted, waiting tRP before ACT
module ddr_cmd_decoder #(
    parameter int BG_WIDTH  = 2,
    parameter int BA_WIDTH  = 2,
    parameter int ROW_WIDTH = 15,
    parameter int COL_WIDTH = 10,
    parameter int T_RCD     = 11,
    parameter int T_RP      = 11,
    parameter int T_RFC     = 208,
    parameter int CL        = 11,
    parameter int CWL       = 9,
    localparam int NUM_BANKS = 2**(BG_WIDTH+BA_WIDTH)
) (
    input  logic                 clock_n,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n_a16,
    input  logic                 cas_n_a15,
    input  logic                 we_n_a14,
    input  logic                 addr17,
    input  logic                 addr13,
    input  logic                 bc_n_a12,
    input  logic                 addr11,
    input  logic                 ap_a10,
    input  logic [9:0]           addr9_0,
    input  logic [BG_WIDTH-1:0]  bg_addr,
    input  logic [BA_WIDTH-1:0]  ba_addr,
    output logic                 cmd_valid,
    output logic [3:0]           cmd_code,
    output logic [BG_WIDTH-1:0]  cmd_bg,
    output logic [BA_WIDTH-1:0]  cmd_ba,
    output logic [ROW_WIDTH-1:0] cmd_row,
    output logic [COL_WIDTH-1:0] cmd_col,
    output logic                 rd_data_start,
    output logic                 wr_data_start,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 refreshing,
    output logic                 protocol_err,
    output logic [2:0]           err_code
);
    localparam int BANK_W = BG_WIDTH + BA_WIDTH;
    localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W  = $clog2(T_MAX + 1);
    localparam int RFC_W  = $clog2(T_RFC + 1);

    localparam logic [3:0] C_NOP = 4'd0, C_ACT = 4'd1, C_PRE = 4'd2, C_PREA = 4'd3, C_RD = 4'd4,
                           C_WR = 4'd5, C_MRS = 4'd6, C_REF = 4'd7, C_ZQCL = 4'd8, C_ILL = 4'd15;

    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_t;

    bank_state_t      bank_state [NUM_BANKS];
    bank_state_t      bank_state_nxt [NUM_BANKS];
    logic [CNT_W-1:0] bank_cnt [NUM_BANKS];
    logic [CNT_W-1:0] bank_cnt_nxt [NUM_BANKS];

    logic [3:0]        dec_code;
    logic [BANK_W-1:0] sel;
    logic              sel_ready, sel_idle, all_idle;
    logic              err_hit, rd_acc, wr_acc, act_acc, pre_one, pre_all, ref_start;
    logic [2:0]        err_nxt;
    logic [RFC_W-1:0]  rfc_cnt;
    logic [CL-1:0]     rd_pipe;
    logic [CWL-1:0]    wr_pipe;
    logic              unused_pins;

    assign unused_pins = addr17;
    assign sel = {bg_addr, ba_addr};

    always_comb begin
        dec_code = C_NOP;
        if (cke && !cs_n) begin
            if (!act_n) begin
                dec_code = C_ACT;
            end else begin
                case ({ras_n_a16, cas_n_a15, we_n_a14})
                    3'b000:  dec_code = C_MRS;
                    3'b001:  dec_code = C_REF;
                    3'b010:  dec_code = ap_a10 ? C_PREA : C_PRE;
                    3'b011:  dec_code = C_ILL;
                    3'b100:  dec_code = C_WR;
                    3'b101:  dec_code = C_RD;
                    3'b110:  dec_code = C_ZQCL;
                    default: dec_code = C_NOP;
                endcase
            end
        end
    end

    // A bank whose timer has just expired is treated as already in its settled state,
    // so a command issued exactly tRCD/tRP after its predecessor is legal.
    always_comb begin
        sel_ready = (bank_state[sel] == B_ACTIVE) ||
                    ((bank_state[sel] == B_ACTIVATING) && (bank_cnt[sel] == '0));
        sel_idle  = (bank_state[sel] == B_IDLE) ||
                    ((bank_state[sel] == B_PRECHARGING) && (bank_cnt[sel] == '0));
        all_idle  = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!((bank_state[i] == B_IDLE) ||
                  ((bank_state[i] == B_PRECHARGING) && (bank_cnt[i] == '0))))
                all_idle = 1'b0;
        end
    end

    always_comb begin
        err_hit   = 1'b0;
        err_nxt   = 3'd0;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        act_acc   = 1'b0;
        pre_one   = 1'b0;
        pre_all   = 1'b0;
        ref_start = 1'b0;
        if (dec_code != C_NOP) begin
            if (refreshing) begin
                err_hit = 1'b1;
                err_nxt = 3'd5;
            end else begin
                case (dec_code)
                    C_ACT: begin
                        if (sel_idle) begin
                            act_acc = 1'b1;
                        end else begin
                            err_hit = 1'b1;
                            err_nxt = (bank_state[sel] == B_PRECHARGING) ? 3'd4 : 3'd2;
                        end
                    end
                    C_RD, C_WR: begin
                        if (sel_ready) begin
                            rd_acc = (dec_code == C_RD);
                            wr_acc = (dec_code == C_WR);
                        end else begin
                            err_hit = 1'b1;
                            err_nxt = (bank_state[sel] == B_ACTIVATING) ? 3'd3 : 3'd1;
                        end
                    end
                    C_PRE:  pre_one = 1'b1;
                    C_PREA: pre_all = 1'b1;
                    C_REF: begin
                        if (all_idle) begin
                            ref_start = 1'b1;
                        end else begin
                            err_hit = 1'b1;
                            err_nxt = 3'd5;
                        end
                    end
                    C_ILL: begin
                        err_hit = 1'b1;
                        err_nxt = 3'd6;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_state_nxt[i] = bank_state[i];
            bank_cnt_nxt[i]   = (bank_cnt[i] == '0) ? '0 : bank_cnt[i] - CNT_W'(1);
            case (bank_state[i])
                B_ACTIVATING:  if (bank_cnt[i] == '0) bank_state_nxt[i] = B_ACTIVE;
                B_PRECHARGING: if (bank_cnt[i] == '0) bank_state_nxt[i] = B_IDLE;
                default: ;
            endcase
            if (act_acc && (sel == BANK_W'(i))) begin
                bank_state_nxt[i] = B_ACTIVATING;
                bank_cnt_nxt[i]   = CNT_W'(T_RCD - 1);
            end
            if ((pre_all || (pre_one && (sel == BANK_W'(i)))) &&
                ((bank_state[i] == B_ACTIVATING) || (bank_state[i] == B_ACTIVE))) begin
                bank_state_nxt[i] = B_PRECHARGING;
                bank_cnt_nxt[i]   = CNT_W'(T_RP - 1);
            end
        end
    end

    always_ff @(posedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= B_IDLE;
                bank_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= bank_state_nxt[i];
                bank_cnt[i]   <= bank_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        bank_open = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            bank_open[i] = (bank_state[i] == B_ACTIVE);
    end

    always_ff @(posedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid     <= 1'b0;
            cmd_code      <= C_NOP;
            cmd_bg        <= '0;
            cmd_ba        <= '0;
            cmd_row       <= '0;
            cmd_col       <= '0;
            protocol_err  <= 1'b0;
            err_code      <= 3'd0;
            refreshing    <= 1'b0;
            rfc_cnt       <= '0;
            rd_pipe       <= '0;
            wr_pipe       <= '0;
            rd_data_start <= 1'b0;
            wr_data_start <= 1'b0;
        end else begin
            cmd_valid <= (dec_code != C_NOP);
            cmd_code  <= dec_code;
            if (dec_code != C_NOP) begin
                cmd_bg  <= bg_addr;
                cmd_ba  <= ba_addr;
                cmd_row <= ROW_WIDTH'({we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0});
                cmd_col <= COL_WIDTH'(addr9_0);
            end
            protocol_err <= err_hit;
            if (err_hit)
                err_code <= err_nxt;
            if (ref_start) begin
                refreshing <= 1'b1;
                rfc_cnt    <= RFC_W'(T_RFC - 1);
            end else if (refreshing) begin
                if (rfc_cnt == '0)
                    refreshing <= 1'b0;
                else
                    rfc_cnt <= rfc_cnt - RFC_W'(1);
            end
            // Bit 0 loads on the command edge, so the final stage lands CL (CWL) clocks later.
            rd_pipe       <= {rd_pipe[CL-2:0], rd_acc};
            wr_pipe       <= {wr_pipe[CWL-2:0], wr_acc};
            rd_data_start <= rd_pipe[CL-1];
            wr_data_start <= wr_pipe[CWL-1];
        end
    end
endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed testbench for ddr_cmd_decoder: decode table, bank timing rules,
// refresh window, data-start latencies and asynchronous reset.
module tb_ddr_cmd_decoder;
    localparam int T_RCD = 11, T_RP = 11, T_RFC = 208, CL = 11, CWL = 9;
    localparam logic [2:0] RCW_RD = 3'b101, RCW_WR = 3'b100, RCW_PRE = 3'b010, RCW_REF = 3'b001;

    logic        clock_n = 1'b0, reset_n;
    logic        cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
    logic        addr17, addr13, bc_n_a12, addr11, ap_a10;
    logic [9:0]  addr9_0;
    logic [1:0]  bg_addr, ba_addr;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [1:0]  cmd_bg, cmd_ba;
    logic [14:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        rd_data_start, wr_data_start, refreshing, protocol_err;
    logic [15:0] bank_open;
    logic [2:0]  err_code;

    int checks = 0;
    int failures = 0;

    ddr_cmd_decoder dut (
        .clock_n(clock_n), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
        .addr17(addr17), .addr13(addr13), .bc_n_a12(bc_n_a12), .addr11(addr11),
        .ap_a10(ap_a10), .addr9_0(addr9_0), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .rd_data_start(rd_data_start),
        .wr_data_start(wr_data_start), .bank_open(bank_open), .refreshing(refreshing),
        .protocol_err(protocol_err), .err_code(err_code)
    );

    always #5 clock_n = ~clock_n;

    task automatic step();
        @(posedge clock_n);
        #1;
    endtask

    task automatic pins_nop();
        cke = 1'b1; cs_n = 1'b0; act_n = 1'b1;
        {ras_n_a16, cas_n_a15, we_n_a14} = 3'b111;
        addr17 = 1'b0; addr13 = 1'b0; bc_n_a12 = 1'b0; addr11 = 1'b0; ap_a10 = 1'b0;
        addr9_0 = '0; bg_addr = '0; ba_addr = '0;
    endtask

    task automatic pins_act(input logic [3:0] bank, input logic [14:0] row);
        pins_nop();
        act_n = 1'b0;
        {ras_n_a16, cas_n_a15} = 2'b00;
        {we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0} = row;
        {bg_addr, ba_addr} = bank;
    endtask

    task automatic pins_cmd(input logic [2:0] rcw, input logic [3:0] bank, input logic ap,
                            input logic [9:0] col);
        pins_nop();
        {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
        ap_a10 = ap;
        addr9_0 = col;
        {bg_addr, ba_addr} = bank;
    endtask

    task automatic idle(input int n);
        pins_nop();
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pins_nop();
        repeat (3) step();
        checks++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd0) begin failures++; $display("FAIL reset_cmd got valid=%0b code=%0d exp 0/0", cmd_valid, cmd_code); end
        checks++; if (bank_open !== 16'h0) begin failures++; $display("FAIL reset_bank_open got %0h exp 0", bank_open); end
        checks++; if ({rd_data_start, wr_data_start, refreshing, protocol_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got %0b exp 0", {rd_data_start, wr_data_start, refreshing, protocol_err}); end
        checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_legal_read();
        pins_act(4'd6, 15'h1A5C);
        step();
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 4'd1) begin failures++; $display("FAIL act_code got valid=%0b code=%0d exp 1/1", cmd_valid, cmd_code); end
        checks++; if (cmd_row !== 15'h1A5C) begin failures++; $display("FAIL act_row got %0h exp 1a5c", cmd_row); end
        checks++; if (cmd_bg !== 2'd1 || cmd_ba !== 2'd2) begin failures++; $display("FAIL act_bank got bg=%0d ba=%0d exp 1/2", cmd_bg, cmd_ba); end
        idle(T_RCD - 1);
        pins_cmd(RCW_RD, 4'd6, 1'b0, 10'h3F8);
        step();
        checks++; if (cmd_code !== 4'd4 || cmd_col !== 10'h3F8) begin failures++; $display("FAIL rd_decode got code=%0d col=%0h exp 4/3f8", cmd_code, cmd_col); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rd_no_err got %0b exp 0", protocol_err); end
        checks++; if (bank_open !== 16'h0040) begin failures++; $display("FAIL rd_bank_open got %0h exp 0040", bank_open); end
        pins_nop();
        for (int k = 1; k <= CL + 1; k++) begin
            step();
            checks++; if (rd_data_start !== (k == CL)) begin failures++; $display("FAIL rd_strobe k=%0d got %0b exp %0b", k, rd_data_start, (k == CL)); end
        end
    endtask

    task automatic test_trcd();
        pins_act(4'd0, 15'h0123);
        step();
        idle(4);
        pins_cmd(RCW_WR, 4'd0, 1'b0, 10'h011);
        step();
        checks++; if (cmd_code !== 4'd5) begin failures++; $display("FAIL trcd_code got %0d exp 5", cmd_code); end
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd3) begin failures++; $display("FAIL trcd_err got err=%0b code=%0d exp 1/3", protocol_err, err_code); end
        pins_nop();
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++; if (wr_data_start !== 1'b0 || (k == 1 && protocol_err !== 1'b0)) begin failures++; $display("FAIL trcd_quiet k=%0d got wr=%0b err=%0b exp 0/0", k, wr_data_start, protocol_err); end
        end
        pins_cmd(RCW_WR, 4'd0, 1'b0, 10'h012);
        step();
        checks++; if (protocol_err !== 1'b0 || err_code !== 3'd3 || cmd_code !== 4'd5) begin failures++; $display("FAIL wr_ok got err=%0b code=%0d cmd=%0d exp 0/3/5", protocol_err, err_code, cmd_code); end
        pins_nop();
        for (int k = 1; k <= CWL + 1; k++) begin
            step();
            checks++; if (wr_data_start !== (k == CWL)) begin failures++; $display("FAIL wr_strobe k=%0d got %0b exp %0b", k, wr_data_start, (k == CWL)); end
        end
    endtask

    task automatic test_precharge();
        checks++; if (bank_open !== 16'h0041) begin failures++; $display("FAIL pre_open_before got %0h exp 0041", bank_open); end
        pins_cmd(RCW_PRE, 4'd0, 1'b1, 10'h0);
        step();
        checks++; if (cmd_code !== 4'd3 || bank_open !== 16'h0) begin failures++; $display("FAIL prea got code=%0d open=%0h exp 3/0", cmd_code, bank_open); end
        idle(3);
        pins_act(4'd0, 15'h0055);
        step();
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd4) begin failures++; $display("FAIL trp_err got err=%0b code=%0d exp 1/4", protocol_err, err_code); end
        idle(6);
        pins_act(4'd0, 15'h0055);
        step();
        checks++; if (protocol_err !== 1'b0 || cmd_code !== 4'd1) begin failures++; $display("FAIL trp_ok got err=%0b code=%0d exp 0/1", protocol_err, cmd_code); end
        pins_act(4'd0, 15'h0056);
        step();
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd2) begin failures++; $display("FAIL act_busy got err=%0b code=%0d exp 1/2", protocol_err, err_code); end
        pins_cmd(RCW_RD, 4'd6, 1'b0, 10'h001);
        step();
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd1) begin failures++; $display("FAIL rd_idle got err=%0b code=%0d exp 1/1", protocol_err, err_code); end
        pins_nop();
        for (int k = 1; k <= CL + 1; k++) begin
            step();
            checks++; if (rd_data_start !== 1'b0) begin failures++; $display("FAIL rd_idle_strobe k=%0d got %0b exp 0", k, rd_data_start); end
        end
    endtask

    task automatic test_refresh();
        pins_cmd(RCW_PRE, 4'd0, 1'b1, 10'h0);
        step();
        idle(T_RP - 1);
        pins_act(4'd3, 15'h0777);
        step();
        idle(T_RCD - 1);
        pins_cmd(RCW_REF, 4'd0, 1'b0, 10'h0);
        step();
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd5 || refreshing !== 1'b0) begin failures++; $display("FAIL ref_open got err=%0b code=%0d ref=%0b exp 1/5/0", protocol_err, err_code, refreshing); end
        checks++; if (bank_open !== 16'h0008) begin failures++; $display("FAIL ref_open_bank got %0h exp 0008", bank_open); end
        pins_cmd(RCW_PRE, 4'd3, 1'b0, 10'h0);
        step();
        idle(T_RP - 1);
        pins_cmd(RCW_REF, 4'd0, 1'b0, 10'h0);
        step();
        checks++; if (refreshing !== 1'b1 || protocol_err !== 1'b0 || cmd_code !== 4'd7) begin failures++; $display("FAIL ref_start got ref=%0b err=%0b code=%0d exp 1/0/7", refreshing, protocol_err, cmd_code); end
        idle(4);
        pins_act(4'd3, 15'h0001);
        step();
        checks++; if (protocol_err !== 1'b1 || err_code !== 3'd5 || cmd_code !== 4'd1) begin failures++; $display("FAIL act_in_ref got err=%0b code=%0d cmd=%0d exp 1/5/1", protocol_err, err_code, cmd_code); end
        idle(T_RFC - 6);
        checks++; if (refreshing !== 1'b1) begin failures++; $display("FAIL ref_last_cycle got %0b exp 1", refreshing); end
        step();
        checks++; if (refreshing !== 1'b0) begin failures++; $display("FAIL ref_end got %0b exp 0", refreshing); end
        pins_act(4'd3, 15'h0002);
        step();
        checks++; if (protocol_err !== 1'b0 || cmd_code !== 4'd1) begin failures++; $display("FAIL act_after_ref got err=%0b code=%0d exp 0/1", protocol_err, cmd_code); end
    endtask

    task automatic test_decode_sweep();
        logic [3:0] exp_code [16];
        logic [3:0] pat;
        exp_code = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                     4'd6, 4'd7, 4'd2, 4'd15, 4'd5, 4'd4, 4'd8, 4'd0};
        for (int i = 0; i < 16; i++) begin
            pins_nop();
            pat = 4'(i);
            {act_n, ras_n_a16, cas_n_a15, we_n_a14} = pat;
            ba_addr = 2'd1;
            step();
            checks++; if (cmd_code !== exp_code[i] || cmd_valid !== (exp_code[i] != 4'd0)) begin failures++; $display("FAIL sweep_%0d got code=%0d valid=%0b exp %0d", i, cmd_code, cmd_valid, exp_code[i]); end
            if (i == 11) begin
                checks++; if (protocol_err !== 1'b1 || err_code !== 3'd6) begin failures++; $display("FAIL illegal_err got err=%0b code=%0d exp 1/6", protocol_err, err_code); end
            end
        end
        pins_cmd(RCW_PRE, 4'd0, 1'b1, 10'h0);
        step();
        checks++; if (cmd_code !== 4'd3) begin failures++; $display("FAIL sweep_prea got %0d exp 3", cmd_code); end
        pins_nop();
        cs_n = 1'b1; act_n = 1'b0;
        ras_n_a16 = 1'bx; cas_n_a15 = 1'bx; we_n_a14 = 1'bx;
        step();
        checks++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd0) begin failures++; $display("FAIL des got valid=%0b code=%0d exp 0/0", cmd_valid, cmd_code); end
        pins_cmd(RCW_REF, 4'd0, 1'b0, 10'h0);
        cke = 1'b0;
        step();
        checks++; if (cmd_valid !== 1'b0 || refreshing !== 1'b0) begin failures++; $display("FAIL cke_low got valid=%0b ref=%0b exp 0/0", cmd_valid, refreshing); end
    endtask

    task automatic test_back_to_back();
        idle(T_RP);
        pins_act(4'd5, 15'h0404);
        step();
        idle(T_RCD - 1);
        for (int j = 0; j < 3; j++) begin
            pins_cmd(RCW_RD, 4'd5, 1'b0, 10'(j));
            step();
            checks++; if (protocol_err !== 1'b0 || cmd_code !== 4'd4) begin failures++; $display("FAIL b2b_rd%0d got err=%0b code=%0d exp 0/4", j, protocol_err, cmd_code); end
        end
        for (int k = 1; k <= CL + 3; k++) begin
            if (k == 1) pins_cmd(RCW_PRE, 4'd5, 1'b0, 10'h0);
            else pins_nop();
            step();
            checks++; if (rd_data_start !== (k >= CL - 2 && k <= CL)) begin failures++; $display("FAIL b2b_strobe k=%0d got %0b exp %0b", k, rd_data_start, (k >= CL - 2 && k <= CL)); end
        end
    endtask

    task automatic test_reset_mid();
        pins_act(4'd5, 15'h0505);
        step();
        idle(T_RCD - 1);
        for (int j = 0; j < 3; j++) begin
            pins_cmd(RCW_RD, 4'd5, 1'b0, 10'h100);
            step();
        end
        idle(3);
        reset_n = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0 || cmd_code !== 4'd0 || bank_open !== 16'h0) begin failures++; $display("FAIL rst_mid_cmd got valid=%0b code=%0d open=%0h exp 0", cmd_valid, cmd_code, bank_open); end
        checks++; if (err_code !== 3'd0 || protocol_err !== 1'b0 || rd_data_start !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got err_code=%0d err=%0b rd=%0b exp 0", err_code, protocol_err, rd_data_start); end
        repeat (2) step();
        reset_n = 1'b1;
        for (int k = 1; k <= CL + 2; k++) begin
            step();
            checks++; if (rd_data_start !== 1'b0) begin failures++; $display("FAIL rst_mid_strobe k=%0d got %0b exp 0", k, rd_data_start); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pins_nop();
        test_reset();
        test_legal_read();
        test_trcd();
        test_precharge();
        test_refresh();
        test_decode_sweep();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
